// File: rtl/tmds_encoder.sv
// Single-channel DVI 1.0 TMDS 8b/10b encoder.
// Three register stages: input capture, transition minimisation (q_m),
// then DC balancing with a running disparity counter or a control token.
module tmds_encoder (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] data_out
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  // Number of ones in a byte, 0..8
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Stage 1 registers
  logic [7:0]        r_data_p1;
  logic [3:0]        r_n1d_p1;
  logic              r_de_p1, r_c0_p1, r_c1_p1;
  // Stage 2 registers
  logic [8:0]        r_qm_p2;
  logic [3:0]        r_n1q_p2, r_n0q_p2;
  logic              r_de_p2, r_c0_p2, r_c1_p2;
  // Stage 3 registers
  logic signed [4:0] r_cnt_p3;
  logic [9:0]        r_dout_p3;

  logic [8:0]        w_qm;
  logic [9:0]        w_dout;
  logic signed [4:0] w_cnt_nxt;
  logic signed [4:0] w_n1q, w_n0q, w_diff;

  // ---- stage 1: capture inputs and count ones of the pixel byte ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data_p1 <= '0;
      r_n1d_p1  <= '0;
      r_de_p1   <= 1'b0;
      r_c0_p1   <= 1'b0;
      r_c1_p1   <= 1'b0;
    end else begin
      r_data_p1 <= data_in;
      r_n1d_p1  <= popcount8(data_in);
      r_de_p1   <= de;
      r_c0_p1   <= c0;
      r_c1_p1   <= c1;
    end
  end

  // Transition-minimised word: XNOR chain for ones-heavy bytes, XOR otherwise
  always_comb begin
    logic       use_xnor;
    logic [8:0] q;
    use_xnor = (r_n1d_p1 > 4'd4) || ((r_n1d_p1 == 4'd4) && !r_data_p1[0]);
    q        = '0;
    q[0]     = r_data_p1[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ r_data_p1[i]) : (q[i-1] ^ r_data_p1[i]);
    q[8]     = ~use_xnor;
    w_qm     = q;
  end

  // ---- stage 2: register q_m with its ones/zeros counts ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_qm_p2  <= '0;
      r_n1q_p2 <= '0;
      r_n0q_p2 <= '0;
      r_de_p2  <= 1'b0;
      r_c0_p2  <= 1'b0;
      r_c1_p2  <= 1'b0;
    end else begin
      r_qm_p2  <= w_qm;
      r_n1q_p2 <= popcount8(w_qm[7:0]);
      r_n0q_p2 <= 4'd8 - popcount8(w_qm[7:0]);
      r_de_p2  <= r_de_p1;
      r_c0_p2  <= r_c0_p1;
      r_c1_p2  <= r_c1_p1;
    end
  end

  // DC balance decision: pick inversion to pull the running disparity to zero
  always_comb begin
    w_n1q     = {1'b0, r_n1q_p2};
    w_n0q     = {1'b0, r_n0q_p2};
    w_diff    = w_n1q - w_n0q;
    w_dout    = TOK_00;
    w_cnt_nxt = '0;
    if (r_de_p2) begin
      if ((r_cnt_p3 == 5'sd0) || (w_n1q == w_n0q)) begin
        w_dout    = {~r_qm_p2[8], r_qm_p2[8], r_qm_p2[8] ? r_qm_p2[7:0] : ~r_qm_p2[7:0]};
        w_cnt_nxt = r_qm_p2[8] ? (r_cnt_p3 + w_diff) : (r_cnt_p3 - w_diff);
      end else if (((r_cnt_p3 > 5'sd0) && (w_n1q > w_n0q)) ||
                   ((r_cnt_p3 < 5'sd0) && (w_n0q > w_n1q))) begin
        w_dout    = {1'b1, r_qm_p2[8], ~r_qm_p2[7:0]};
        w_cnt_nxt = r_cnt_p3 + (r_qm_p2[8] ? 5'sd2 : 5'sd0) - w_diff;
      end else begin
        w_dout    = {1'b0, r_qm_p2[8], r_qm_p2[7:0]};
        w_cnt_nxt = r_cnt_p3 - (r_qm_p2[8] ? 5'sd0 : 5'sd2) + w_diff;
      end
    end else begin
      case ({r_c1_p2, r_c0_p2})
        2'b00:   w_dout = TOK_00;
        2'b01:   w_dout = TOK_01;
        2'b10:   w_dout = TOK_10;
        default: w_dout = TOK_11;
      endcase
    end
  end

  // ---- stage 3: output symbol and running disparity ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_p3  <= '0;
      r_dout_p3 <= '0;
    end else begin
      r_cnt_p3  <= w_cnt_nxt;
      r_dout_p3 <= w_dout;
    end
  end

  assign data_out = r_dout_p3;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: stimulus pushes model expectations,
// a monitor pops one per clock and compares, decodes and tracks disparity.
module tb_tmds_encoder;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] data_in   = '0;
  logic       c0 = 1'b0, c1 = 1'b0, de = 1'b0;
  logic [9:0] data_out;

  tmds_encoder dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data_in  (data_in),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .data_out (data_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [7:0] d;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_cnt    = 0;
  int   act_cnt  = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] token(input logic cc1, input logic cc0);
    case ({cc1, cc0})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] qq, d;
    qq   = s[9] ? ~s[7:0] : s[7:0];
    d[0] = qq[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
    return d;
  endfunction

  // Reference: encode one input, track disparity as the ones/zeros balance
  // of all emitted active symbols since the last blanking.
  task automatic drive(input logic de_i, input logic c1_i, input logic c0_i,
                       input logic [7:0] d_i, input bit has_k, input logic [9:0] k);
    logic [8:0] qm;
    logic [9:0] s;
    bit         xn, inv;
    int         n1, n0;
    exp_t       e;
    @(negedge sys_clk);
    de = de_i; c1 = c1_i; c0 = c0_i; data_in = d_i;
    if (!de_i) begin
      s     = token(c1_i, c0_i);
      m_cnt = 0;
    end else begin
      xn    = ($countones(d_i) > 4) || ($countones(d_i) == 4 && !d_i[0]);
      qm[0] = d_i[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d_i[i]) : (qm[i-1] ^ d_i[i]);
      qm[8] = !xn;
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (m_cnt == 0 || n1 == n0)                        inv = !qm[8];
      else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) inv = 1'b1;
      else                                               inv = 1'b0;
      s     = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
      m_cnt = m_cnt + 2 * $countones(s) - 10;
    end
    e.sym = has_k ? k : s;
    e.de  = de_i;
    e.d   = d_i;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic push_tok00();
    exp_t e;
    e.sym = 10'h354; e.de = 1'b0; e.d = '0; e.cnt = 0;
    q.push_back(e);
  endtask

  // Asynchronous reset mid-cycle; release with de=0,c=00 presented so the
  // first three symbols after release are all the 00 token.
  task automatic reset_seq();
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check(data_out == 10'h000, "rst_async", data_out, 0);
    data_in = 8'($urandom); de = 1'b1; c0 = 1'($urandom); c1 = 1'($urandom);
    @(negedge sys_clk);
    check(data_out == 10'h000, "rst_hold", data_out, 0);
    q.delete();
    m_cnt = 0;
    push_tok00();
    push_tok00();
    de = 1'b0; c0 = 1'b0; c1 = 1'b0; data_in = 8'($urandom);
    push_tok00();
    sys_rst_n = 1'b1;
  endtask

  // Monitor: one symbol per clock, compared after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_n) begin
        act_cnt = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        check(data_out == e.sym, "symbol", data_out, e.sym);
        if (e.de) begin
          act_cnt = act_cnt + 2 * $countones(data_out) - 10;
          check(decode(data_out) == e.d, "decode", decode(data_out), e.d);
          check(act_cnt == e.cnt, "disparity", act_cnt, e.cnt);
          check(act_cnt >= -10 && act_cnt <= 10, "disp_bound", act_cnt, 10);
        end else begin
          act_cnt = 0;
        end
      end
    end
  end

  initial begin
    int active;
    #3 check(data_out == 10'h000, "rst_initial", data_out, 0);
    reset_seq();

    // control tokens
    drive(0, 0, 0, 8'h00, 1, 10'h354);
    drive(0, 0, 1, 8'h00, 1, 10'h0AB);
    drive(0, 1, 0, 8'h00, 1, 10'h154);
    drive(0, 1, 1, 8'h00, 1, 10'h2AB);

    // all-zero pixels alternate inversion: cnt -8, +2, -6
    drive(1, 0, 0, 8'h00, 1, 10'h100);
    drive(1, 0, 0, 8'h00, 1, 10'h3FF);
    drive(1, 0, 0, 8'h00, 1, 10'h100);

    // all-ones pixel from blanking: XNOR path, cnt -8
    drive(0, 0, 0, 8'h00, 1, 10'h354);
    drive(1, 0, 0, 8'hFF, 1, 10'h200);

    // one blanking symbol clears the disparity
    drive(0, 0, 0, 8'h00, 1, 10'h354);
    drive(1, 0, 0, 8'h00, 1, 10'h100);

    // reset in the middle of an active line
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'($urandom), 0, '0);
    reset_seq();
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 8'($urandom), 0, '0);

    // de toggling every cycle
    for (int i = 0; i < 40; i++)
      drive(1'(i & 1), 1'($urandom), 1'($urandom), 8'($urandom), 0, '0);

    // random lines with random-length blanking
    active = 0;
    while (active < 10000) begin
      for (int i = 0; i < 250; i++) begin
        drive(1, 0, 0, 8'($urandom), 0, '0);
        active++;
      end
      repeat ($urandom_range(1, 12)) drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 0, '0);
    end

    repeat (3) @(posedge sys_clk);
    #2 check(q.size() == 0, "drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
